// File: rtl/stream_demux_pkg.sv
// stream_demux_pkg: shared defaults, select-width derivation and error-count ceiling for the 1-to-N demux
package stream_demux_pkg;
  localparam int DATA_W_DEF = 8;
  localparam int NCH_DEF = 4;
  localparam logic [7:0] ERR_MAX = 8'd255;
  function automatic int sel_w(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/stream_demux_slot.sv
// stream_demux_slot: one channel's output register and valid flag (ports: clk, rst, load, ready, d -> q, valid, free)
module stream_demux_slot
  import stream_demux_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              ready,
  input  logic [DATA_W-1:0] d,
  output logic [DATA_W-1:0] q,
  output logic              valid,
  output logic              free
);
  assign free = !valid || ready;
  always_ff @(posedge clk)
    if (rst) begin
      valid <= 1'b0;
      q     <= '0;
    end else begin
      if (load) q <= d;
      valid <= load || (valid && !ready);
    end
endmodule

// File: rtl/stream_demux_1ton.sv
// stream_demux_1ton: routes one valid/ready input stream to NCH registered output channels (unicast by sel, or broadcast), counting beats dropped for an illegal sel in err_cnt
module stream_demux_1ton
  import stream_demux_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int NCH = NCH_DEF,
  localparam int SEL_W = sel_w(NCH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_W-1:0]     din,
  input  logic                  din_valid,
  output logic                  din_ready,
  input  logic [SEL_W-1:0]      sel,
  input  logic                  bcast,
  output logic [NCH*DATA_W-1:0] dout,
  output logic [NCH-1:0]        dout_valid,
  input  logic [NCH-1:0]        dout_ready,
  output logic [7:0]            err_cnt
);
  logic [NCH-1:0] free;
  logic [NCH-1:0] load;
  logic           legal;
  logic           accept;
  assign legal = bcast || ({1'b0, sel} < (SEL_W + 1)'(NCH));
  // beats with an illegal sel are always taken so they can be discarded
  assign din_ready = !rst && (bcast ? &free : (legal ? free[sel] : 1'b1));
  assign accept = din_valid && din_ready;
  for (genvar k = 0; k < NCH; k++) begin : g_ch
    assign load[k] = accept && (bcast || sel == SEL_W'(k));
    stream_demux_slot #(.DATA_W(DATA_W)) u_slot (
      .clk  (clk),
      .rst  (rst),
      .load (load[k]),
      .ready(dout_ready[k]),
      .d    (din),
      .q    (dout[k*DATA_W +: DATA_W]),
      .valid(dout_valid[k]),
      .free (free[k])
    );
  end
  always_ff @(posedge clk)
    if (rst) err_cnt <= '0;
    else if (accept && !legal && err_cnt != ERR_MAX) err_cnt <= err_cnt + 8'd1;
endmodule

// File: doc/stream_demux_1ton.md
STREAM_DEMUX_1TON -- requirements
Module: stream_demux_1toN

Interface
REQ-001 Parameter DATA_W, default 8: payload width in bits.
REQ-002 Parameter NCH, default 4: output channel count, legal range 2..16.
REQ-003 Derived constant SEL_W = max(1, ceil(log2(NCH))).
REQ-004 Port clk, input, 1: single clock; all state updates on the rising edge.
REQ-005 Port rst, input, 1: reset, synchronous and active-high.
REQ-006 Port din, input, DATA_W: input payload.
REQ-007 Port din_valid, input, 1: input beat present.
REQ-008 Port din_ready, output, 1: block accepts the beat this cycle.
REQ-009 Port sel, input, SEL_W: target channel for the beat.
REQ-010 Port bcast, input, 1: when high, the beat goes to all NCH channels; sel is ignored.
REQ-011 Port dout, output, NCH*DATA_W: channel k payload occupies bits [k*DATA_W +: DATA_W].
REQ-012 Port dout_valid, output, NCH: per-channel beat present.
REQ-013 Port dout_ready, input, NCH: per-channel consumer ready.
REQ-014 Port err_cnt, output, 8: saturating count of dropped beats with an illegal sel.

Function
REQ-015 Each channel SHALL hold a one-entry output register (slot) plus a valid flag.
REQ-016 A slot is free when its valid flag is low, or when it is valid and its dout_ready is high in the same cycle.
REQ-017 A beat is accepted when din_valid and din_ready are both high on a clock edge.
REQ-018 Unicast (bcast=0, sel<NCH): din_ready SHALL equal the free status of slot sel.
REQ-019 Broadcast (bcast=1): din_ready SHALL be high only when all NCH slots are free.
REQ-020 On acceptance, every target slot SHALL load din and set its valid flag.
REQ-021 dout_valid SHALL rise on the edge after acceptance, giving a latency of 1 cycle.
REQ-022 A slot that is valid with dout_ready high and no new load SHALL clear its valid flag at the edge.
REQ-023 A simultaneous drain and load of the same slot SHALL leave it valid with the new data, with no bubble.
REQ-024 While dout_valid[k] is high and dout_ready[k] is low, dout[k] SHALL stay stable.
REQ-025 Illegal sel (bcast=0, sel>=NCH, only possible when NCH is not a power of 2):
- din_ready is high;
- the beat is accepted and discarded;
- err_cnt increments by 1 and saturates at 255.
REQ-026 din_ready SHALL be combinational from sel, bcast, the slot states and dout_ready, and SHALL NOT depend on din_valid.
REQ-027 Channels SHALL be independent: a stalled channel SHALL NOT block unicast beats to other channels.
REQ-028 Beats to one channel SHALL be delivered in acceptance order.
REQ-029 Sustained throughput SHALL be 1 beat per cycle when the target is draining every cycle.

Reset
REQ-030 While rst is high at an edge:
- all dout_valid bits clear to 0;
- err_cnt clears to 0;
- dout clears to 0;
- no beat is accepted.
REQ-031 Reset mid-transfer SHALL discard slot contents; the first accept is possible on the first edge after rst goes low.
REQ-032 din_ready SHALL be 0 while rst is high.

Structure
REQ-033 Package stream_demux_pkg SHALL hold:
- DATA_W and NCH defaults;
- the SEL_W derivation function;
- the ERR_MAX=255 constant.
REQ-034 Sub-module stream_demux_slot SHALL implement one channel's register, valid flag and free logic, instantiated NCH times by generate.

Verification
REQ-035 NCH=4, DATA_W=8, all dout_ready=1; send 0x11,0x22,0x33,0x44 on sel 0..3 in consecutive cycles -> each dout_valid[k] is high for exactly 1 cycle, 1 cycle after its accept, with the matching data.
REQ-036 dout_ready[2]=0; send 0xA5 to sel 2, then 0x5A to sel 2 -> second beat has din_ready=0 and dout[2] holds 0xA5; raise dout_ready[2] -> 0xA5 drains and 0x5A is accepted in the same cycle, then appears the next cycle.
REQ-037 dout_ready[1]=0 with slot 1 full; broadcast 0xFF -> din_ready=0; release channel 1 -> accepted, and all four dout_valid rise together with 0xFF.
REQ-038 NCH=3, sel=3, 300 beats -> din_ready=1 for every beat, no dout_valid, err_cnt saturates at 255.
REQ-039 Assert rst for 1 cycle while slots 0 and 3 are valid -> dout_valid=0000 and err_cnt=0 on the next edge, and a beat is accepted on the first edge after rst goes low.
REQ-040 Random unicast traffic with random dout_ready on all channels for 10000 cycles -> a scoreboard shows per-channel order preserved, no loss, no duplication.
